// File: rtl/pe_arbiter.sv
// Eight-requester arbiter: priority-encoded winner, registered one-hot grant held
// until release, disable or hold-timeout. Define PE_ARB_RR_EN for round-robin selection.
module pe_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] y,
  output logic       gnt_vld,
  output logic       timeout
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_gnt, w_gnt_nxt;
  logic [2:0]    r_y, w_y_nxt;
  logic          r_vld, w_vld_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]    r_mask, w_mask_nxt;

  logic [7:0]    w_ereq;
  logic [2:0]    w_win;
  logic          w_win_vld;
  logic          w_grant;
  logic          w_hold_expired;

  assign w_ereq         = req & ~r_mask;
  assign w_grant        = (r_state == S_IDLE) && en && w_win_vld;
  assign w_hold_expired = (MAX_HOLD != 0) && (r_cnt == HOLD_LAST);

`ifdef PE_ARB_RR_EN
  logic [2:0] r_ptr;

  // Search downward from ptr-1, wrapping; 3-bit subtraction gives the mod-8 wrap.
  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!w_win_vld && w_ereq[r_ptr - 3'(k)]) begin
        w_win     = r_ptr - 3'(k);
        w_win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ptr <= '0;
    else if (w_grant) r_ptr <= w_win;
  end
`else
  always_comb begin
    w_win = '0;
    for (int k = 0; k < 8; k++) begin
      if (w_ereq[k]) w_win = 3'(k);
    end
    w_win_vld = |w_ereq;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_y       <= '0;
      r_vld     <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_mask    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_y       <= w_y_nxt;
      r_vld     <= w_vld_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mask    <= w_mask_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_BUSY;
      S_BUSY:  if (!en || !req[r_y] || w_hold_expired) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_gnt_nxt     = '0;
    w_y_nxt       = '0;
    w_vld_nxt     = 1'b0;
    w_timeout_nxt = 1'b0;
    w_cnt_nxt     = '0;
    w_mask_nxt    = r_mask & req;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_gnt_nxt = 8'b1 << w_win;
          w_y_nxt   = w_win;
          w_vld_nxt = 1'b1;
        end
      end
      S_BUSY: begin
        if (en && req[r_y]) begin
          if (w_hold_expired) begin
            // Setting after the clear makes a same-edge set win.
            w_timeout_nxt   = 1'b1;
            w_mask_nxt[r_y] = 1'b1;
          end else begin
            w_gnt_nxt = r_gnt;
            w_y_nxt   = r_y;
            w_vld_nxt = 1'b1;
            w_cnt_nxt = (MAX_HOLD != 0) ? r_cnt + 1'b1 : r_cnt;
          end
        end
      end
      default: ;
    endcase
  end

  assign gnt     = r_gnt;
  assign y       = r_y;
  assign gnt_vld = r_vld;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_pe_arbiter.sv
// Self-checking bench for pe_arbiter: directed vectors, per-cycle comparison
// against a rule-level behavioural model, plus hand-computed literal checks.
module tb_pe_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk, rst_n, en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] y;
  logic       gnt_vld, timeout;

  int total, bad;
  bit chk_en;

  pe_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt), .y(y), .gnt_vld(gnt_vld), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef PE_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  // Search downward from a start index with wrap; fixed priority always starts at 7.
  function automatic int pick(logic [7:0] e, int p);
    int start;
    start = RR_MODE ? ((p + 7) % 8) : 7;
    for (int k = 0; k < 8; k++) begin
      if (e[(start - k + 8) % 8]) return (start - k + 8) % 8;
    end
    return -1;
  endfunction

  // Behavioural model: owner/hold-cycle bookkeeping straight from the rules.
  bit         m_busy, m_to;
  int         m_owner, m_hold, m_ptr;
  logic [7:0] m_mask;

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0] nm, e;
    int w;
    if (!rst_n) begin
      m_busy <= 1'b0; m_to <= 1'b0; m_owner <= 0; m_hold <= 0; m_ptr <= 0; m_mask <= '0;
    end else begin
      nm = m_mask & req;
      e  = req & ~m_mask;
      m_to <= 1'b0;
      if (!m_busy) begin
        if (en && e != 0) begin
          w = pick(e, m_ptr);
          m_busy <= 1'b1; m_owner <= w; m_hold <= 1; m_ptr <= w;
        end
      end else if (!en || !req[m_owner]) begin
        m_busy <= 1'b0;
      end else if (MAX_HOLD != 0 && m_hold == MAX_HOLD) begin
        m_busy <= 1'b0; m_to <= 1'b1; nm[m_owner] = 1'b1;
      end else begin
        m_hold <= m_hold + 1;
      end
      m_mask <= nm;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_gnt", gnt, m_busy ? 32'(8'h01 << m_owner) : 32'h0);
      check("cyc_y", y, m_busy ? 32'(m_owner) : 32'h0);
      check("cyc_vld", gnt_vld, 32'(m_busy));
      check("cyc_timeout", timeout, 32'(m_to));
    end
  end

  int exp_order [9];

  initial begin
    total = 0; bad = 0; chk_en = 1'b0;
    rst_n = 1'b0; en = 1'b0; req = '0;
    if (RR_MODE) exp_order = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    else         exp_order = '{7, 7, 7, 7, 7, 7, 7, 7, 7};

    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_y", y, 0);
    check("rst_vld", gnt_vld, 0);
    check("rst_timeout", timeout, 0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Fixed priority and release
    en = 1'b1; req = 8'h2C;
    @(negedge clk);
    check("fp_gnt", gnt, 8'h20);
    check("fp_y", y, 3'd5);
    check("fp_vld", gnt_vld, 1);
    req = 8'h0C;
    @(negedge clk);
    check("fp_rel_gnt", gnt, 0);
    @(negedge clk);
    check("fp_next_gnt", gnt, 8'h08);
    check("fp_next_y", y, 3'd3);
    req = '0;
    repeat (2) @(negedge clk);

    // Enable gating
    en = 1'b0; req = 8'hFF;
    repeat (3) @(negedge clk);
    check("en_off_vld", gnt_vld, 0);
    en = 1'b1;
    @(negedge clk);
    check("en_on_vld", gnt_vld, 1);
    en = 1'b0;
    @(negedge clk);
    check("en_drop_gnt", gnt, 0);
    check("en_drop_timeout", timeout, 0);
    req = '0; en = 1'b1;
    @(negedge clk);

    // Asynchronous reset mid-grant
    req = 8'h80;
    @(negedge clk);
    check("mr_gnt_before", gnt, 8'h80);
    #2 rst_n = 1'b0;
    #1;
    check("mr_gnt", gnt, 0);
    check("mr_y", y, 0);
    check("mr_vld", gnt_vld, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);

    // Hold timeout with a single requester
    req = 8'h01;
    @(negedge clk);
    for (int i = 0; i < MAX_HOLD; i++) begin
      check("to_hold_vld", gnt_vld, 1);
      @(negedge clk);
    end
    check("to_pulse", timeout, 1);
    check("to_pulse_vld", gnt_vld, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("to_masked_vld", gnt_vld, 0);
      check("to_pulse_gone", timeout, 0);
    end
    req = 8'h00;
    @(negedge clk);
    req = 8'h01;
    @(negedge clk);
    check("to_regrant", gnt, 8'h01);
    req = '0;
    repeat (2) @(negedge clk);

    // Timeout with a competitor
    req = 8'h81;
    @(negedge clk);
    check("cmp_first", gnt, 8'h80);
    repeat (MAX_HOLD) @(negedge clk);
    check("cmp_timeout", timeout, 1);
    @(negedge clk);
    check("cmp_second", gnt, 8'h01);
    check("cmp_second_y", y, 3'd0);
    repeat (8) @(negedge clk);
    check("cmp_both_masked", gnt_vld, 0);
    req = '0;
    repeat (2) @(negedge clk);

    // Grant order with every winner releasing and re-requesting
    for (int i = 0; i < 9; i++) begin
      req = 8'hFF;
      @(negedge clk);
      check("order_y", y, 32'(exp_order[i]));
      check("order_vld", gnt_vld, 1);
      req = 8'hFF & ~(8'h01 << exp_order[i]);
      @(negedge clk);
    end

    chk_en = 1'b0;
    req = '0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_arbiter.md
# pe_arbiter

Eight-requester arbiter built around the 8-to-3 priority encoding used in the datapath. It samples a request vector, selects one winner, and holds a registered grant until the winner releases its request, enable drops, or a hold-timeout expires. It sits between the request sources and the shared resource and supplies a one-hot grant plus the encoded winner index.

## Interface
- MAX_HOLD, 16, maximum consecutive BUSY cycles per grant; 0 disables the timeout
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  arbiter enable; 0 forces IDLE and blocks new grants
- req  input  8  request vector, bit k = requester k, level-sensitive
- gnt  output  8  registered one-hot grant, all zeros when no grant
- y  output  3  registered winner index; 3'b000 when gnt_vld=0
- gnt_vld  output  1  registered; 1 while a grant is held
- timeout  output  1  registered one-cycle pulse when a grant is force-released

## Operation
- Reset (rst_n=0, asynchronous): state=IDLE, gnt=0, y=0, gnt_vld=0, timeout=0, hold counter=0, mask=0, rotation pointer=0.
- Effective request: ereq = req & ~mask.
- States: IDLE, BUSY.
- IDLE: if en=1 and ereq!=0, select winner w, load gnt=1<<w, y=w, gnt_vld=1, counter=0, go BUSY. Otherwise stay IDLE with outputs zero.
- Default selection is fixed priority: the highest set index of ereq wins, 7 highest and 0 lowest.
- BUSY, checked in this order at each edge:
  - en=0: go IDLE, clear the grant, no timeout pulse.
  - req[y]=0: release, go IDLE, clear the grant.
  - MAX_HOLD!=0 and counter==MAX_HOLD-1: force release, go IDLE, clear the grant, timeout=1 for one cycle, set mask[y]=1.
  - Otherwise: stay BUSY, counter+1.
- The counter is $clog2(MAX_HOLD+1) bits wide and cannot wrap, because it is reset on every grant.
- Mask: mask[k] is cleared on any edge where req[k]=0 is sampled. This means a timed-out requester must drop its request for at least one cycle before it can win again. A mask bit set and cleared on the same edge resolves to set.
- Every release passes through IDLE, so there is always at least one idle cycle between grants.

## Timing
- Grant latency: req sampled in IDLE at edge N produces gnt, y and gnt_vld valid after edge N.
- Release: req[y] sampled low at edge N clears gnt after edge N. The earliest next grant follows edge N+1.
- A request that is asserted and then dropped before being sampled in IDLE is never granted.
- timeout is high for exactly the cycle after the force-release edge, and gnt_vld=0 during that cycle.
- A mid-grant reset clears all outputs immediately, without waiting for a clock edge.
- Requests from non-winners during BUSY are ignored. They are evaluated only in IDLE.

## Configuration
- PE_ARB_RR_EN defined: round-robin selection.
  - A 3-bit pointer p (reset 0) is maintained.
  - The search starts at index (p-1) mod 8 and proceeds downward, wrapping from 0 to 7. After reset this gives 7 the highest priority, identical to fixed priority.
  - The first set bit of ereq found wins, and p is loaded with w on every grant.
- PE_ARB_RR_EN undefined: fixed priority as above, and no pointer register exists.

## Test plan
- Reset mid-grant: req=8'h80 and granted, then assert rst_n=0 asynchronously -> gnt=0, y=0, gnt_vld=0 before the next edge.
- Fixed priority: en=1, req=8'h2C -> one cycle later gnt=8'h20, y=3'd5, gnt_vld=1. Then drop req[5] -> gnt=0 next cycle, and the following cycle gnt=8'h08, y=3'd3.
- Enable gating: en=0, req=8'hFF -> gnt_vld stays 0. Drop en during BUSY -> gnt=0 next cycle with timeout=0.
- Timeout, MAX_HOLD=4, req=8'h01 held high -> gnt_vld high for 4 cycles, then timeout=1 for 1 cycle. Requester 0 is not regranted while req[0] stays 1. After req[0] goes 0 for one cycle then 1 again -> regranted.
- Timeout with competitor, MAX_HOLD=4: req=8'h81 held -> 7 granted, times out, then 0 is granted while 7 remains masked.
- PE_ARB_RR_EN, req=8'hFF, each winner releasing after one BUSY cycle and re-requesting -> grant order 7,6,5,4,3,2,1,0,7. Without the macro the same stimulus grants 7 every time.
